prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Receive-side counterpart of the PRBS9 generator.
- Self-synchronises to an incoming PRBS9 bit stream, e.g. the QPSK rx decision output, with no seed or delay alignment needed.
- Declares and drops lock, flags bit errors, and keeps saturating bit/error counters for BER measurement.
- Sits after the rx slicer in the loopback datapath and runs at the symbol-enable rate (one bit per enable pulse).

Parameters:
LOCK_CNT, 32, consecutive correct predictions required in VERIFY before declaring lock (1..255)
LOSS_WINDOW, 64, LOCKED-state observation window length in enabled bits (2..1024)
LOSS_THRESH, 8, errors within one window that force loss of lock (1..LOSS_WINDOW)
CNT_W, 32, width of bit_count and error_count

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
enable  input  1  bit strobe; all state advances only on cycles with enable=1
clr  input  1  synchronous clear of bit_count/error_count (priority over increment)
bit_in  input  1  received bit, valid when enable=1
locked  output  1  registered; 1 while state is LOCKED
error_flag  output  1  registered one-cycle pulse per mismatched bit while LOCKED
bit_count  output  CNT_W  saturating count of enabled bits checked while LOCKED
error_count  output  CNT_W  saturating count of errors while LOCKED
inverted  output  1  detected stream polarity (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=SEARCH, shift register sr=0, fill/match/window counters=0, all outputs 0.
- Polynomial x^9+x^5+1; prediction p = sr[8]^sr[4]; compared bit c = bit_in ^ inverted.
- SEARCH: each enabled bit shifts sr <= {sr[7:0], c}, fill_cnt++. After the 9th bit, go to VERIFY with match_cnt=0.
- VERIFY: on each enabled bit, sr <= {sr[7:0], c}.
  - If c==p: match_cnt++. Reaching LOCK_CNT moves to LOCKED, with window counter and window error counter set to 0.
  - If c!=p: go to SEARCH, fill_cnt=0.
  - Counters do not count in VERIFY.
- LOCKED: sr <= {sr[7:0], p} (free-running reference, so input errors do not propagate).
  - err = (c!=p).
  - bit_count +1 every enabled bit; error_count +1 when err. Both saturate at all-ones.
  - win_idx counts 0..LOSS_WINDOW-1 and wraps; win_err accumulates err.
  - On the enabled bit where win_idx==LOSS_WINDOW-1, that bit's err is included in the check. If total >= LOSS_THRESH, go to SEARCH (fill_cnt=0); otherwise clear win_err and continue.
- Timing: locked and error_flag update on the clock edge that consumes the enabled bit, i.e. visible the cycle after enable=1.
  - error_flag is forced 0 on non-enabled cycles.
- clr=1 zeroes both counters that cycle and overrides any simultaneous increment. clr does not affect state.
- With enable=0: sr, counters and state hold.
- Reset mid-operation returns everything to reset values immediately. After release, a full re-acquire is needed: 9 fill bits + LOCK_CNT matches.

Optional Feature:
- Macro PRBS_CHK_POLARITY_EN.
- When defined, VERIFY also tracks inv_cnt of consecutive bits with c!=p.
  - If inv_cnt reaches LOCK_CNT first: toggle inverted and go to SEARCH. Inverted QPSK branches from phase ambiguity then lock.
  - inverted persists until reset.
- When undefined, inverted is constant 0 and any VERIFY mismatch returns to SEARCH.

Test Plan:
- Clean lock: PRBS9 from seed 9'h1AA, enable 1-in-4 cycles → locked rises after enabled bit 41 (9+32), error_flag never pulses; 1000 bits later bit_count=1000, error_count=0.
- Single error: once locked, flip one bit → exactly one error_flag pulse the cycle after that enable, error_count=1, locked stays 1, and the following bits check clean.
- Loss of lock: 8 flipped bits inside one 64-bit window → locked falls after window bit 64. Then a clean stream relocks after 41 bits. 7 flipped bits per window → lock held.
- Counter control: clr asserted on the same cycle as an error → error_count=0 next cycle. Force error_count to all-ones, then inject an error → value holds.
- Reset/enable: rst pulled low while locked → all outputs 0 asynchronously. enable held low for 100 cycles → no output change.
- Polarity (PRBS_CHK_POLARITY_EN): inverted PRBS9 → inverted=1 and locked=1 within 9+32+9+32 enabled bits, error_count=0. Without the macro → never locks, inverted=0.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS9 (x^9 + x^5 + 1) receive checker.
// Locks onto an incoming PRBS9 stream without seed alignment. Declares and
// drops lock, pulses error_flag per mismatched bit while locked, and keeps
// saturating bit/error counters for BER measurement. Advances one bit per
// enable strobe.
//
// Optional build macro PRBS_CHK_POLARITY_EN: when defined, the checker also
// detects an inverted stream, flips its compare polarity and then locks.
// When undefined, inverted is tied to 0.
module prbs_checker #(
    parameter int LOCK_CNT    = 32,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clr,
    input  logic             bit_in,
    output logic             locked,
    output logic             error_flag,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] error_count,
    output logic             inverted
);

    localparam int WIN_W  = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
    localparam int WERR_W = $clog2(LOSS_WINDOW + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(LOSS_WINDOW - 1);
    localparam logic [WERR_W-1:0] THRESH     = WERR_W'(LOSS_THRESH);
    localparam logic [7:0]        MATCH_LAST = 8'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [8:0]        sr;
    logic [3:0]        fill_cnt;
    logic [7:0]        match_cnt;
    logic [WIN_W-1:0]  win_idx;
    logic [WERR_W-1:0] win_err;
    logic [WERR_W-1:0] win_total;
    logic              c;
    logic              p;
    logic              err;

`ifndef PRBS_CHK_POLARITY_EN
    assign inverted = 1'b0;
`endif

    // Compared bit, PRBS9 prediction from the reference register, and mismatch.
    assign c         = bit_in ^ inverted;
    assign p         = sr[8] ^ sr[4];
    assign err       = c ^ p;
    assign win_total = win_err + WERR_W'(err);

`ifdef PRBS_CHK_POLARITY_EN
    logic [7:0] inv_cnt;
`endif

    // Acquisition / lock state machine with registered locked and error_flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            sr         <= '0;
            fill_cnt   <= '0;
            match_cnt  <= '0;
            win_idx    <= '0;
            win_err    <= '0;
            locked     <= 1'b0;
            error_flag <= 1'b0;
`ifdef PRBS_CHK_POLARITY_EN
            inv_cnt    <= '0;
            inverted   <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below reads the pre-edge values of sr, counters and state.
            error_flag <= 1'b0;
            if (enable) begin
                unique case (state)
                    SEARCH: begin
                        sr <= {sr[7:0], c};
                        if (fill_cnt == 4'd8) begin
                            state     <= VERIFY;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
`ifdef PRBS_CHK_POLARITY_EN
                            inv_cnt   <= '0;
`endif
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end

                    VERIFY: begin
                        sr <= {sr[7:0], c};
`ifdef PRBS_CHK_POLARITY_EN
                        // A run of matches proves normal polarity, a run of
                        // mismatches proves inversion; breaking a run restarts.
                        if (!err) begin
                            if (inv_cnt != '0) begin
                                state    <= SEARCH;
                                fill_cnt <= '0;
                            end else if (match_cnt == MATCH_LAST) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                win_idx <= '0;
                                win_err <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            if (match_cnt != '0) begin
                                state    <= SEARCH;
                                fill_cnt <= '0;
                            end else if (inv_cnt == MATCH_LAST) begin
                                inverted <= ~inverted;
                                state    <= SEARCH;
                                fill_cnt <= '0;
                            end else begin
                                inv_cnt <= inv_cnt + 1'b1;
                            end
                        end
`else
                        if (!err) begin
                            if (match_cnt == MATCH_LAST) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                win_idx <= '0;
                                win_err <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            state    <= SEARCH;
                            fill_cnt <= '0;
                        end
`endif
                    end

                    LOCKED: begin
                        // Free-running reference: received errors never enter sr.
                        sr         <= {sr[7:0], p};
                        error_flag <= err;
                        if (win_idx == WIN_LAST) begin
                            win_idx <= '0;
                            win_err <= '0;
                            if (win_total >= THRESH) begin
                                state    <= SEARCH;
                                fill_cnt <= '0;
                                locked   <= 1'b0;
                            end
                        end else begin
                            win_idx <= win_idx + 1'b1;
                            win_err <= win_total;
                        end
                    end

                    default: begin
                        state    <= SEARCH;
                        fill_cnt <= '0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating BER counters; clr wins over any increment in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_count   <= '0;
            error_count <= '0;
        end else if (clr) begin
            bit_count   <= '0;
            error_count <= '0;
        end else if (enable && state == LOCKED) begin
            if (bit_count != '1) begin
                bit_count <= bit_count + 1'b1;
            end
            if (err && error_count != '1) begin
                error_count <= error_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed self-checking bench for prbs_checker.
// A second instance with 4-bit counters and a permissive loss threshold
// shares the stimulus and is used to observe counter saturation.
module tb_prbs_checker;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic enable = 1'b0;
    logic clr    = 1'b0;
    logic bit_in = 1'b0;

    logic        locked, error_flag, inverted;
    logic [31:0] bit_count, error_count;
    logic        s_locked, s_error_flag, s_inverted;
    logic [3:0]  s_bit_count, s_error_count;

    int   checks = 0;
    int   errors = 0;
    logic [8:0] g;
    logic inv_mode;
    logic exp_locked;
    int   exp_bits;
    int   win_pos;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clr         (clr),
        .bit_in      (bit_in),
        .locked      (locked),
        .error_flag  (error_flag),
        .bit_count   (bit_count),
        .error_count (error_count),
        .inverted    (inverted)
    );

    prbs_checker #(.LOSS_THRESH(64), .CNT_W(4)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clr         (clr),
        .bit_in      (bit_in),
        .locked      (s_locked),
        .error_flag  (s_error_flag),
        .bit_count   (s_bit_count),
        .error_count (s_error_count),
        .inverted    (s_inverted)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference PRBS9 source: x[n] = x[n-9] ^ x[n-5].
    function automatic logic gen_next();
        logic b;
        b = g[8] ^ g[4];
        g = {g[7:0], b};
        return b;
    endfunction

    // One enabled bit followed by three idle cycles (1-in-4 enable).
    task automatic send_bit(input logic flip);
        logic b;
        b = gen_next();
        @(negedge clk);
        enable = 1'b1;
        bit_in = b ^ flip ^ inv_mode;
        @(posedge clk);
        #1;
        check("error_flag", {63'd0, error_flag}, {63'd0, exp_locked & flip});
        if (exp_locked) begin
            exp_bits++;
            win_pos++;
        end
        @(negedge clk);
        enable = 1'b0;
        bit_in = 1'($urandom());
        @(posedge clk);
        #1;
        check("error_flag_idle", {63'd0, error_flag}, 64'd0);
        repeat (2) begin
            @(negedge clk);
            bit_in = 1'($urandom());
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, {63'd0, locked}, 64'd0);
        check({tag, "_error_flag"}, {63'd0, error_flag}, 64'd0);
        check({tag, "_bit_count"}, {32'd0, bit_count}, 64'd0);
        check({tag, "_error_count"}, {32'd0, error_count}, 64'd0);
        check({tag, "_inverted"}, {63'd0, inverted}, 64'd0);
        check({tag, "_sat_locked"}, {63'd0, s_locked}, 64'd0);
        check({tag, "_sat_error_count"}, {60'd0, s_error_count}, 64'd0);
    endtask

    initial begin
        g          = 9'h1AA;
        inv_mode   = 1'b0;
        exp_locked = 1'b0;
        exp_bits   = 0;
        win_pos    = 0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Clean lock: 9 fill bits + 32 matches
        for (int i = 1; i <= 41; i++) begin
            send_bit(1'b0);
            if (i == 40) check("locked_bit40", {63'd0, locked}, 64'd0);
        end
        check("locked_bit41", {63'd0, locked}, 64'd1);
        check("sat_locked_bit41", {63'd0, s_locked}, 64'd1);
        exp_locked = 1'b1;
        win_pos    = 0;

        repeat (1000) send_bit(1'b0);
        check("bit_count_1000", {32'd0, bit_count}, 64'd1000);
        check("error_count_clean", {32'd0, error_count}, 64'd0);
        check("sat_bit_count_hold", {60'd0, s_bit_count}, 64'd15);
        check("sat_error_count_clean", {60'd0, s_error_count}, 64'd0);

        // Single error
        send_bit(1'b1);
        check("single_error_count", {32'd0, error_count}, 64'd1);
        check("single_locked", {63'd0, locked}, 64'd1);
        check("sat_single_error_count", {60'd0, s_error_count}, 64'd1);
        repeat (20) send_bit(1'b0);
        check("after_single_error_count", {32'd0, error_count}, 64'd1);
        check("after_single_bit_count", {32'd0, bit_count}, 64'd1021);

        // clr on the same cycle as an error
        begin
            logic b;
            b = gen_next();
            @(negedge clk);
            enable = 1'b1;
            clr    = 1'b1;
            bit_in = ~b;
            @(posedge clk);
            #1;
            check("clr_error_flag", {63'd0, error_flag}, 64'd1);
            check("clr_error_count", {32'd0, error_count}, 64'd0);
            check("clr_bit_count", {32'd0, bit_count}, 64'd0);
            check("clr_locked", {63'd0, locked}, 64'd1);
            check("clr_sat_error_count", {60'd0, s_error_count}, 64'd0);
            @(negedge clk);
            enable = 1'b0;
            clr    = 1'b0;
            exp_bits = 0;
            win_pos++;
        end
        send_bit(1'b0);
        check("post_clr_bit_count", {32'd0, bit_count}, 64'd1);

        // Loss of lock: 8 errors at the start of one window
        while (win_pos % 64 != 0) send_bit(1'b0);
        for (int i = 1; i <= 64; i++) begin
            send_bit(i <= 8);
            if (i == 63) check("loss_locked_bit63", {63'd0, locked}, 64'd1);
        end
        check("loss_locked_bit64", {63'd0, locked}, 64'd0);
        check("loss_error_count", {32'd0, error_count}, 64'd8);
        check("sat_loss_locked", {63'd0, s_locked}, 64'd1);
        check("sat_loss_error_count", {60'd0, s_error_count}, 64'd8);
        exp_locked = 1'b0;

        // Relock on a clean stream
        for (int i = 1; i <= 41; i++) begin
            send_bit(1'b0);
            if (i == 40) check("relock_bit40", {63'd0, locked}, 64'd0);
        end
        check("relock_bit41", {63'd0, locked}, 64'd1);
        exp_locked = 1'b1;
        win_pos    = 0;

        // 7 errors per window for two windows: lock held
        for (int i = 0; i < 128; i++) begin
            send_bit((i % 64) < 7);
            if (i == 63) check("seven_locked_w1", {63'd0, locked}, 64'd1);
        end
        check("seven_locked_w2", {63'd0, locked}, 64'd1);
        check("seven_error_count", {32'd0, error_count}, 64'd22);
        check("sat_error_count_15", {60'd0, s_error_count}, 64'd15);
        check("sat_bit_count_15", {60'd0, s_bit_count}, 64'd15);
        send_bit(1'b1);
        check("sat_error_count_hold", {60'd0, s_error_count}, 64'd15);
        check("extra_error_count", {32'd0, error_count}, 64'd23);

        // enable held low for 100 cycles: nothing moves
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            enable = 1'b0;
            bit_in = 1'($urandom());
            @(posedge clk);
            #1;
            check("idle_locked", {63'd0, locked}, 64'd1);
            check("idle_error_flag", {63'd0, error_flag}, 64'd0);
            check("idle_bit_count", {32'd0, bit_count}, 64'(exp_bits));
            check("idle_error_count", {32'd0, error_count}, 64'd23);
        end
        repeat (10) send_bit(1'b0);
        check("resume_error_count", {32'd0, error_count}, 64'd23);
        check("resume_bit_count", {32'd0, bit_count}, 64'(exp_bits));

        // Asynchronous reset while locked
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst        = 1'b1;
        exp_locked = 1'b0;
        exp_bits   = 0;

        // Full re-acquire after reset
        for (int i = 1; i <= 41; i++) begin
            send_bit(1'b0);
            if (i == 40) check("reacq_bit40", {63'd0, locked}, 64'd0);
        end
        check("reacq_bit41", {63'd0, locked}, 64'd1);
        exp_locked = 1'b1;

        // Inverted stream from reset
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        exp_locked = 1'b0;
        exp_bits   = 0;
        inv_mode   = 1'b1;
`ifdef PRBS_CHK_POLARITY_EN
        for (int i = 1; i <= 82; i++) begin
            send_bit(1'b0);
            if (i == 81) check("pol_locked_bit81", {63'd0, locked}, 64'd0);
        end
        check("pol_locked_bit82", {63'd0, locked}, 64'd1);
        check("pol_inverted", {63'd0, inverted}, 64'd1);
        check("pol_error_count", {32'd0, error_count}, 64'd0);
        exp_locked = 1'b1;
        repeat (20) send_bit(1'b0);
        check("pol_clean_error_count", {32'd0, error_count}, 64'd0);
        check("pol_clean_bit_count", {32'd0, bit_count}, 64'd20);
`else
        for (int i = 1; i <= 123; i++) begin
            send_bit(1'b0);
            check("nopol_locked", {63'd0, locked}, 64'd0);
        end
        check("nopol_inverted", {63'd0, inverted}, 64'd0);
        check("nopol_error_count", {32'd0, error_count}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
